pdp8_trace_buffer: RTL and testbench
====================================

# pdp8_trace_buffer

Synthesizable instruction-trace capture block for the PDP-8 core. Monitors the CPU's major-state bus and architectural registers, and records one entry per instruction fetch into a circular buffer of parametrised depth. Supports continuous, stop-when-full and trigger-on-PC capture modes, with halt detection. The buffer is read back over a simple indexed port, replacing simulation-only fetch tracing with hardware usable on the FPGA build.

## Interface
- DEPTH, 64: number of trace entries; power of two, 4..4096.
- AW, $clog2(DEPTH): entry index width.
- CNT_W, 32: fetch counter width.
- FETCH_STATE, 4'b0000: CPU state value that marks an instruction fetch.
- HALT_STATE, 4'b1100: CPU state value that marks a halt.

- clk  in  1  system clock, shared with the CPU.
- reset  in  1  synchronous, active-low reset.
- state  in  4  CPU major state.
- pc  in  12  CPU program counter.
- mb  in  12  CPU memory buffer (instruction word at fetch).
- l  in  1  CPU link.
- ac  in  12  CPU accumulator.
- ion  in  1  CPU interrupt enable.
- arm  in  1  one-cycle pulse; clears the buffer and starts capture.
- mode  in  2  0 = continuous wrap, 1 = stop when full, 2 = trigger, 3 = reserved (treated as 0).
- trig_pc  in  12  PC value that fires the trigger in mode 2.
- post_cnt  in  AW  entries to record after the trigger entry (mode 2).
- rd_idx  in  AW  read index; 0 = oldest valid entry.
- rd_data  out  38  {pc, mb, l, ac, ion} of the selected entry; registered.
- count  out  AW+1  valid entries, saturating at DEPTH.
- capturing  out  1  FSM is in ARMED or POST.
- triggered  out  1  sticky; set when the trigger fires.
- halted  out  1  sticky; set when HALT_STATE is seen while capturing.
- fetches  out  CNT_W  fetches seen since arm; saturates at all-ones.

## Operation
- FSM states: IDLE, ARMED, POST, DONE.
  - IDLE → ARMED on arm.
  - ARMED → POST on a trigger entry (mode 2 only).
  - ARMED → DONE when count reaches DEPTH (mode 1 only).
  - POST → DONE when the post counter hits 0.
  - ARMED or POST → DONE on halt.
  - An arm pulse in any state restarts capture: wr_ptr, count, fetches, triggered and halted are cleared, the FSM goes to ARMED, and in-flight capture is discarded.
- Fetch event: state == FETCH_STATE and the previous-cycle state != FETCH_STATE. This is edge-detected, so a multi-cycle fetch records exactly once.
- On a fetch event in ARMED or POST:
  - write the record at wr_ptr;
  - wr_ptr increments modulo DEPTH;
  - count increments, saturating at DEPTH;
  - fetches increments, saturating.
- Trigger: in mode 2 and ARMED, a fetch event with pc == trig_pc.
  - The trigger entry is written.
  - triggered is set.
  - The post counter loads post_cnt.
  - If post_cnt == 0, the FSM goes straight to DONE.
  - In POST, each later fetch event is written and decrements the counter; the write made when the counter reaches 0 is the last.
- Halt: state == HALT_STATE in ARMED or POST sets halted and moves the FSM to DONE. No entry is written for the halt cycle.
- Simultaneous fetch event and full condition (mode 1): the entry that makes count == DEPTH is written, then the FSM goes to DONE.
- Mode changes apply on the next cycle. Changing mode mid-capture is legal.
- Readout:
  - Physical address = (count < DEPTH) ? rd_idx : (wr_ptr + rd_idx) mod DEPTH.
  - rd_idx ≥ count returns undefined data.
  - Reads are legal during capture. A write and a read of the same address in the same cycle returns the old data.

## Timing
- Reset (reset = 0 at a clk edge):
  - FSM goes to IDLE.
  - All outputs go to 0, including rd_data = 0.
  - Buffer contents are not cleared.
  - Reset has priority over arm.
- arm sampled at edge N: capturing = 1 after edge N. A fetch event at edge N+1 is the first one recorded.
- A record is written at the same edge where the fetch event is sampled. count and fetches reflect it after that edge.
- rd_data is valid one cycle after rd_idx is presented.
- triggered, halted and capturing update at the edge where the causing event is sampled.

## Structure
- Package pdp8_trace_pkg holds:
  - FETCH_STATE and HALT_STATE defaults;
  - the mode encodings (MODE_CONT, MODE_FULL, MODE_TRIG);
  - the FSM state encoding;
  - REC_W = 38 and the record field offsets.
- Sub-module pdp8_trace_ram is a DEPTH×REC_W simple dual-port RAM: one synchronous write port and one registered read port, with read-old-data on collision.

## Test plan
- Continuous wrap: DEPTH = 8, mode 0, 10 single-cycle fetches with pc = 0..9 → count = 8, fetches = 10, rd_idx 0 gives pc = 2, rd_idx 7 gives pc = 9.
- Stop when full: mode 1, DEPTH = 8, 12 fetches → capturing drops after the 8th, count = 8, fetches = 8, rd_idx 7 gives pc = 7.
- Trigger: mode 2, trig_pc = 0200, post_cnt = 3, pc sequence 0176..0210 → triggered = 1, last entry pc = 0203, FSM in DONE.
- Fetch edge-detect: FETCH_STATE held 3 cycles, then a non-fetch state, then FETCH_STATE again → exactly 2 entries recorded.
- Halt: HALT_STATE after 5 fetches in mode 0 → halted = 1, count = 5, no further writes on subsequent fetch states.
- Reset and re-arm: reset mid-POST → all outputs 0 and FSM in IDLE. Then arm → count starts at 0 and triggered = 0.

Source files
------------

// File: rtl/pdp8_trace_pkg.sv
// Shared types and constants for the PDP-8 instruction-trace buffer.
// Holds default state codes, capture-mode and FSM encodings, and the record layout.
package pdp8_trace_pkg;

  localparam logic [3:0] FETCH_STATE_DEF = 4'b0000;
  localparam logic [3:0] HALT_STATE_DEF  = 4'b1100;

  typedef enum logic [1:0] {
    MODE_CONT = 2'd0,
    MODE_FULL = 2'd1,
    MODE_TRIG = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } fsm_e;

  // Record is {pc, mb, l, ac, ion}, ion in bit 0.
  localparam int REC_W      = 38;
  localparam int REC_ION_LSB = 0;
  localparam int REC_AC_LSB  = 1;
  localparam int REC_L_LSB   = 13;
  localparam int REC_MB_LSB  = 14;
  localparam int REC_PC_LSB  = 26;

  function automatic logic [REC_W-1:0] pack_rec(
    input logic [11:0] pc,
    input logic [11:0] mb,
    input logic        l,
    input logic [11:0] ac,
    input logic        ion
  );
    logic [REC_W-1:0] rec;
    rec                      = '0;
    rec[REC_PC_LSB +: 12]    = pc;
    rec[REC_MB_LSB +: 12]    = mb;
    rec[REC_L_LSB]           = l;
    rec[REC_AC_LSB +: 12]    = ac;
    rec[REC_ION_LSB]         = ion;
    return rec;
  endfunction

endpackage

// File: rtl/pdp8_trace_ram.sv
// Trace storage: DEPTH x W simple dual-port RAM, synchronous write, registered read (1 cycle).
// No backpressure; a same-address write and read in one cycle returns the old word.
module pdp8_trace_ram
  import pdp8_trace_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH),
  parameter int W     = REC_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic [AW-1:0] ra,
  output logic [W-1:0]  rd
);

  logic [W-1:0] mem [DEPTH];

  // Storage is deliberately not reset; only the read register clears.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd <= '0;
    end else begin
      rd <= mem[ra];
    end
  end

endmodule

// File: rtl/pdp8_trace_buffer.sv
// Records one {pc,mb,l,ac,ion} entry per CPU fetch into a circular buffer; write at the fetch edge, rd_data 1 cycle after rd_idx.
// No backpressure: the CPU is never stalled, capture simply stops in DONE.
module pdp8_trace_buffer
  import pdp8_trace_pkg::*;
#(
  parameter int         DEPTH       = 64,
  parameter int         AW          = $clog2(DEPTH),
  parameter int         CNT_W       = 32,
  parameter logic [3:0] FETCH_STATE = FETCH_STATE_DEF,
  parameter logic [3:0] HALT_STATE  = HALT_STATE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       state,
  input  logic [11:0]      pc,
  input  logic [11:0]      mb,
  input  logic             l,
  input  logic [11:0]      ac,
  input  logic             ion,
  input  logic             arm,
  input  logic [1:0]       mode,
  input  logic [11:0]      trig_pc,
  input  logic [AW-1:0]    post_cnt,
  input  logic [AW-1:0]    rd_idx,
  output logic [REC_W-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             capturing,
  output logic             triggered,
  output logic             halted,
  output logic [CNT_W-1:0] fetches
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  fsm_e          fsm;
  mode_e         mode_eff;
  logic [3:0]    prev_state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] post_ctr;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   count_inc;
  logic          fetch_evt;
  logic          halt_evt;
  logic          full_stop;
  logic          is_trig;
  logic          wr_en;

  always_comb begin
    mode_eff = MODE_CONT;
    if (mode == MODE_TRIG) begin
      mode_eff = MODE_TRIG;
    end else if (mode == MODE_FULL) begin
      mode_eff = MODE_FULL;
    end
  end

  assign fetch_evt = (state == FETCH_STATE) && (prev_state != FETCH_STATE);
  assign halt_evt  = (state == HALT_STATE);
  assign full_stop = (mode_eff == MODE_FULL) && (count == DEPTH_CNT);
  assign is_trig   = (mode_eff == MODE_TRIG) && (pc == trig_pc);
  assign count_inc = (count == DEPTH_CNT) ? count : count + (AW+1)'(1);
  assign capturing = (fsm == ST_ARMED) || (fsm == ST_POST);

  // Arm and reset both suppress the write so a restart never keeps a stale entry.
  assign wr_en = reset && !arm && fetch_evt && !halt_evt &&
                 ((fsm == ST_POST) || ((fsm == ST_ARMED) && !full_stop));

  // Once the buffer has wrapped, the oldest entry sits at wr_ptr.
  assign rd_addr = (count < DEPTH_CNT) ? rd_idx : wr_ptr + rd_idx;

  always_ff @(posedge clk) begin
    prev_state <= state;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm       <= ST_IDLE;
      wr_ptr    <= '0;
      count     <= '0;
      fetches   <= '0;
      post_ctr  <= '0;
      triggered <= 1'b0;
      halted    <= 1'b0;
    end else if (arm) begin
      fsm       <= ST_ARMED;
      wr_ptr    <= '0;
      count     <= '0;
      fetches   <= '0;
      post_ctr  <= '0;
      triggered <= 1'b0;
      halted    <= 1'b0;
    end else begin
      case (fsm)
        ST_ARMED, ST_POST: begin
          if (halt_evt) begin
            halted <= 1'b1;
            fsm    <= ST_DONE;
          end else if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
            count  <= count_inc;
            if (fetches != '1) begin
              fetches <= fetches + CNT_W'(1);
            end
            if (fsm == ST_ARMED) begin
              if (is_trig) begin
                triggered <= 1'b1;
                post_ctr  <= post_cnt;
                fsm       <= (post_cnt == '0) ? ST_DONE : ST_POST;
              end else if ((mode_eff == MODE_FULL) && (count_inc == DEPTH_CNT)) begin
                fsm <= ST_DONE;
              end
            end else begin
              // The write that takes the counter to zero is the final one.
              post_ctr <= post_ctr - AW'(1);
              if (post_ctr == AW'(1)) begin
                fsm <= ST_DONE;
              end
            end
          end else if ((fsm == ST_ARMED) && full_stop) begin
            fsm <= ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  pdp8_trace_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (REC_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_en),
    .wa    (wr_ptr),
    .wd    (pack_rec(pc, mb, l, ac, ion)),
    .ra    (rd_addr),
    .rd    (rd_data)
  );

endmodule

// File: tb/tb_pdp8_trace_buffer.sv
// Bench for pdp8_trace_buffer at DEPTH = 8: table of capture scenarios plus hand-written
// edge-detect, halt and reset/re-arm sequences; read data checked through an expected-value queue.
module tb_pdp8_trace_buffer;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int CNT_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [3:0]        state;
  logic [11:0]       pc;
  logic [11:0]       mb;
  logic              l;
  logic [11:0]       ac;
  logic              ion;
  logic              arm;
  logic [1:0]        mode;
  logic [11:0]       trig_pc;
  logic [AW-1:0]     post_cnt;
  logic [AW-1:0]     rd_idx;
  logic [37:0]       rd_data;
  logic [AW:0]       count;
  logic              capturing;
  logic              triggered;
  logic              halted;
  logic [CNT_W-1:0]  fetches;

  always #5 clk = ~clk;

  pdp8_trace_buffer #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .state     (state),
    .pc        (pc),
    .mb        (mb),
    .l         (l),
    .ac        (ac),
    .ion       (ion),
    .arm       (arm),
    .mode      (mode),
    .trig_pc   (trig_pc),
    .post_cnt  (post_cnt),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data),
    .count     (count),
    .capturing (capturing),
    .triggered (triggered),
    .halted    (halted),
    .fetches   (fetches)
  );

  typedef struct {
    logic [1:0]    mode;
    int            n;
    logic [11:0]   base;
    logic [11:0]   trig;
    logic [AW-1:0] post;
    int            exp_count;
    int            exp_fetches;
    logic          exp_trig;
    logic          exp_capt;
    logic [AW-1:0] ra;
    logic [11:0]   pa;
    logic [AW-1:0] rb;
    logic [11:0]   pb;
  } vec_t;

  vec_t        vecs [6];
  logic [37:0] exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;

  localparam logic [3:0] ST_FETCH = 4'b0000;
  localparam logic [3:0] ST_OTHER = 4'b0001;
  localparam logic [3:0] ST_HALT  = 4'b1100;

  function automatic logic [37:0] mk_rec(input logic [11:0] p);
    logic [11:0] inc;
    inc = p + 12'd1;
    return {p, p ^ 12'o5252, p[0], inc, p[1]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic arm_capture(input logic [1:0] m, input logic [11:0] t, input logic [AW-1:0] p);
    mode     = m;
    trig_pc  = t;
    post_cnt = p;
    arm      = 1'b1;
    tick();
    arm      = 1'b0;
  endtask

  task automatic fetch(input logic [11:0] p, input int hold);
    state = ST_FETCH;
    pc    = p;
    mb    = p ^ 12'o5252;
    l     = p[0];
    ac    = p + 12'd1;
    ion   = p[1];
    repeat (hold) tick();
    state = ST_OTHER;
    tick();
  endtask

  task automatic rd_check(input string nm, input logic [AW-1:0] idx, input logic [11:0] p);
    logic [37:0] e;
    rd_idx = idx;
    exp_q.push_back(mk_rec(p));
    tick();
    e = exp_q.pop_front();
    chk(nm, 64'(rd_data), 64'(e));
  endtask

  task automatic status(input string nm, input int c, input int f, input logic t,
                        input logic cp, input logic h);
    chk({nm, " count"}, 64'(count), 64'(c));
    chk({nm, " fetches"}, 64'(fetches), 64'(f));
    chk({nm, " triggered"}, 64'(triggered), 64'(t));
    chk({nm, " capturing"}, 64'(capturing), 64'(cp));
    chk({nm, " halted"}, 64'(halted), 64'(h));
  endtask

  initial begin
    // mode, n, base, trig, post, count, fetches, trig, capt, ra, pa, rb, pb
    vecs[0] = '{2'd0, 10, 12'd0,   12'd0,    3'd0, 8, 10, 1'b0, 1'b1, 3'd0, 12'd2,   3'd7, 12'd9};
    vecs[1] = '{2'd1, 12, 12'd0,   12'd0,    3'd0, 8, 8,  1'b0, 1'b0, 3'd7, 12'd7,   3'd0, 12'd0};
    vecs[2] = '{2'd2, 11, 12'o176, 12'o200,  3'd3, 6, 6,  1'b1, 1'b0, 3'd5, 12'o203, 3'd0, 12'o176};
    vecs[3] = '{2'd2, 5,  12'o176, 12'o200,  3'd0, 3, 3,  1'b1, 1'b0, 3'd2, 12'o200, 3'd0, 12'o176};
    vecs[4] = '{2'd3, 5,  12'd100, 12'd0,    3'd0, 5, 5,  1'b0, 1'b1, 3'd4, 12'd104, 3'd0, 12'd100};
    vecs[5] = '{2'd2, 9,  12'd10,  12'o7777, 3'd0, 8, 9,  1'b0, 1'b1, 3'd0, 12'd11,  3'd7, 12'd18};

    reset    = 1'b0;
    state    = ST_OTHER;
    pc       = '0;
    mb       = '0;
    l        = 1'b0;
    ac       = '0;
    ion      = 1'b0;
    arm      = 1'b0;
    mode     = 2'd0;
    trig_pc  = '0;
    post_cnt = '0;
    rd_idx   = '0;
    tick();
    tick();
    status("reset", 0, 0, 1'b0, 1'b0, 1'b0);
    chk("reset rd_data", 64'(rd_data), 64'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      arm_capture(vecs[i].mode, vecs[i].trig, vecs[i].post);
      for (int k = 0; k < vecs[i].n; k++) begin
        fetch(vecs[i].base + 12'(k), 1);
      end
      status($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_fetches,
             vecs[i].exp_trig, vecs[i].exp_capt, 1'b0);
      rd_check($sformatf("vec%0d rd_a", i), vecs[i].ra, vecs[i].pa);
      rd_check($sformatf("vec%0d rd_b", i), vecs[i].rb, vecs[i].pb);
    end

    // A fetch state held for several cycles records once.
    arm_capture(2'd0, 12'd0, 3'd0);
    fetch(12'd50, 3);
    fetch(12'd51, 1);
    status("edge", 2, 2, 1'b0, 1'b1, 1'b0);
    rd_check("edge rd0", 3'd0, 12'd50);
    rd_check("edge rd1", 3'd1, 12'd51);

    // Halt ends capture; later fetches are ignored.
    arm_capture(2'd0, 12'd0, 3'd0);
    for (int k = 0; k < 5; k++) fetch(12'd200 + 12'(k), 1);
    state = ST_HALT;
    tick();
    state = ST_OTHER;
    tick();
    for (int k = 5; k < 8; k++) fetch(12'd200 + 12'(k), 1);
    status("halt", 5, 5, 1'b0, 1'b0, 1'b1);
    rd_check("halt rd4", 3'd4, 12'd204);

    // Reset in the middle of post-trigger capture, then re-arm.
    arm_capture(2'd2, 12'o200, 3'd5);
    fetch(12'o176, 1);
    fetch(12'o177, 1);
    fetch(12'o200, 1);
    fetch(12'o201, 1);
    status("post", 4, 4, 1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    arm   = 1'b1;
    tick();
    arm   = 1'b0;
    status("midreset", 0, 0, 1'b0, 1'b0, 1'b0);
    chk("midreset rd_data", 64'(rd_data), 64'd0);
    reset = 1'b1;
    tick();
    fetch(12'd300, 1);
    status("idle", 0, 0, 1'b0, 1'b0, 1'b0);
    arm_capture(2'd0, 12'd0, 3'd0);
    status("rearm", 0, 0, 1'b0, 1'b1, 1'b0);
    fetch(12'd301, 1);
    chk("rearm count", 64'(count), 64'd1);
    rd_check("rearm rd0", 3'd0, 12'd301);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
